// File: rtl/id_ex_register_if.sv
// ID/EX stage bus: run/stall/flush controls, ID-side fields (*_i) and EX-side fields (*_o).
// The ID_EX_PERF_CNT_EN macro adds the bubble/stall performance counter outputs.
interface id_ex_register_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int FUNCT_W = 10,
    parameter int CNT_W   = 32
);
    logic               start_i;
    logic               stall_i;
    logic               flush_i;
    logic               valid_i;
    logic [1:0]         ALUOp_i;
    logic               ALUSrc_i;
    logic               RegWrite_i;
    logic               MemWrite_i;
    logic               MemRead_i;
    logic               MemtoReg_i;
    logic               Branch_i;
    logic [DATA_W-1:0]  PC_i;
    logic [DATA_W-1:0]  RS1data_i;
    logic [DATA_W-1:0]  RS2data_i;
    logic [DATA_W-1:0]  Imm_i;
    logic [FUNCT_W-1:0] funct_i;
    logic [ADDR_W-1:0]  RS1addr_i;
    logic [ADDR_W-1:0]  RS2addr_i;
    logic [ADDR_W-1:0]  RDaddr_i;

    logic               valid_o;
    logic [1:0]         ALUOp_o;
    logic               ALUSrc_o;
    logic               RegWrite_o;
    logic               MemWrite_o;
    logic               MemRead_o;
    logic               MemtoReg_o;
    logic               Branch_o;
    logic [DATA_W-1:0]  PC_o;
    logic [DATA_W-1:0]  RS1data_o;
    logic [DATA_W-1:0]  RS2data_o;
    logic [DATA_W-1:0]  Imm_o;
    logic [FUNCT_W-1:0] funct_o;
    logic [ADDR_W-1:0]  RS1addr_o;
    logic [ADDR_W-1:0]  RS2addr_o;
    logic [ADDR_W-1:0]  RDaddr_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0]   bubble_cnt_o;
    logic [CNT_W-1:0]   stall_cnt_o;
`endif

    modport master (
        output start_i, stall_i, flush_i, valid_i, ALUOp_i, ALUSrc_i, RegWrite_i,
               MemWrite_i, MemRead_i, MemtoReg_i, Branch_i, PC_i, RS1data_i,
               RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
        input  valid_o, ALUOp_o, ALUSrc_o, RegWrite_o, MemWrite_o, MemRead_o,
               MemtoReg_o, Branch_o, PC_o, RS1data_o, RS2data_o, Imm_o, funct_o,
               RS1addr_o, RS2addr_o, RDaddr_o
`ifdef ID_EX_PERF_CNT_EN
        , input bubble_cnt_o, stall_cnt_o
`endif
    );

    modport slave (
        input  start_i, stall_i, flush_i, valid_i, ALUOp_i, ALUSrc_i, RegWrite_i,
               MemWrite_i, MemRead_i, MemtoReg_i, Branch_i, PC_i, RS1data_i,
               RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
        output valid_o, ALUOp_o, ALUSrc_o, RegWrite_o, MemWrite_o, MemRead_o,
               MemtoReg_o, Branch_o, PC_o, RS1data_o, RS2data_o, Imm_o, funct_o,
               RS1addr_o, RS2addr_o, RDaddr_o
`ifdef ID_EX_PERF_CNT_EN
        , output bubble_cnt_o, stall_cnt_o
`endif
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with hold (start_i low / stall_i), bubble insertion (flush_i) and valid bit.
// Optional bubble/stall performance counters are enabled with the ID_EX_PERF_CNT_EN macro.
module id_ex_register #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int FUNCT_W = 10,
    parameter int CNT_W   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    id_ex_register_if.slave      bus
);
    typedef struct packed {
        logic               valid;
        logic [1:0]         alu_op;
        logic               alu_src;
        logic               reg_write;
        logic               mem_write;
        logic               mem_read;
        logic               mem_to_reg;
        logic               branch;
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  rs1_data;
        logic [DATA_W-1:0]  rs2_data;
        logic [DATA_W-1:0]  imm;
        logic [FUNCT_W-1:0] funct;
        logic [ADDR_W-1:0]  rs1_addr;
        logic [ADDR_W-1:0]  rs2_addr;
        logic [ADDR_W-1:0]  rd_addr;
    } stage_t;

    stage_t in_stage_s;
    stage_t stage_d;
    stage_t stage_q;

    assign in_stage_s = '{
        valid:      bus.valid_i,
        alu_op:     bus.ALUOp_i,
        alu_src:    bus.ALUSrc_i,
        reg_write:  bus.RegWrite_i,
        mem_write:  bus.MemWrite_i,
        mem_read:   bus.MemRead_i,
        mem_to_reg: bus.MemtoReg_i,
        branch:     bus.Branch_i,
        pc:         bus.PC_i,
        rs1_data:   bus.RS1data_i,
        rs2_data:   bus.RS2data_i,
        imm:        bus.Imm_i,
        funct:      bus.funct_i,
        rs1_addr:   bus.RS1addr_i,
        rs2_addr:   bus.RS2addr_i,
        rd_addr:    bus.RDaddr_i
    };

    // Next-stage selection: run-hold beats flush, flush beats stall; a bubble clears every field
    always_comb begin
        stage_d = stage_q;
        if (!bus.start_i) begin
            stage_d = stage_q;
        end else if (bus.flush_i) begin
            stage_d = '0;
        end else if (bus.stall_i) begin
            stage_d = stage_q;
        end else begin
            stage_d = in_stage_s;
        end
    end

    // Stage register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign bus.valid_o    = stage_q.valid;
    assign bus.ALUOp_o    = stage_q.alu_op;
    assign bus.ALUSrc_o   = stage_q.alu_src;
    assign bus.RegWrite_o = stage_q.reg_write;
    assign bus.MemWrite_o = stage_q.mem_write;
    assign bus.MemRead_o  = stage_q.mem_read;
    assign bus.MemtoReg_o = stage_q.mem_to_reg;
    assign bus.Branch_o   = stage_q.branch;
    assign bus.PC_o       = stage_q.pc;
    assign bus.RS1data_o  = stage_q.rs1_data;
    assign bus.RS2data_o  = stage_q.rs2_data;
    assign bus.Imm_o      = stage_q.imm;
    assign bus.funct_o    = stage_q.funct;
    assign bus.RS1addr_o  = stage_q.rs1_addr;
    assign bus.RS2addr_o  = stage_q.rs2_addr;
    assign bus.RDaddr_o   = stage_q.rd_addr;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    // A stall that coincides with a flush is not counted as a stall cycle
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (bus.start_i && bus.flush_i) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else if (bus.start_i && bus.stall_i) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            bubble_cnt_d = bubble_cnt_q;
            stall_cnt_d  = stall_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.bubble_cnt_o = bubble_cnt_q;
    assign bus.stall_cnt_o  = stall_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register: directed scenarios followed by randomized traffic.
module tb_id_ex_register;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int FUNCT_W = 10;
    localparam int CNT_W   = 32;

    typedef struct packed {
        logic [1:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        mem_to_reg;
        logic        branch;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [9:0]  funct;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        valid;
    } fields_t;

    typedef struct packed {
        fields_t     f;
        logic [31:0] bubbles;
        logic [31:0] stalls;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    exp_t    exp_q[$];
    fields_t model_f;
    logic [31:0] model_bubbles;
    logic [31:0] model_stalls;

    id_ex_register_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUNCT_W(FUNCT_W), .CNT_W(CNT_W)) bus ();

    id_ex_register #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUNCT_W(FUNCT_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic fields_t sample_outputs();
        fields_t s;
        s.alu_op     = bus.ALUOp_o;
        s.alu_src    = bus.ALUSrc_o;
        s.reg_write  = bus.RegWrite_o;
        s.mem_write  = bus.MemWrite_o;
        s.mem_read   = bus.MemRead_o;
        s.mem_to_reg = bus.MemtoReg_o;
        s.branch     = bus.Branch_o;
        s.pc         = bus.PC_o;
        s.rs1_data   = bus.RS1data_o;
        s.rs2_data   = bus.RS2data_o;
        s.imm        = bus.Imm_o;
        s.funct      = bus.funct_o;
        s.rs1_addr   = bus.RS1addr_o;
        s.rs2_addr   = bus.RS2addr_o;
        s.rd_addr    = bus.RDaddr_o;
        s.valid      = bus.valid_o;
        return s;
    endfunction

    function automatic fields_t random_fields();
        fields_t s;
        s.alu_op     = 2'($urandom);
        s.alu_src    = 1'($urandom);
        s.reg_write  = 1'($urandom);
        s.mem_write  = 1'($urandom);
        s.mem_read   = 1'($urandom);
        s.mem_to_reg = 1'($urandom);
        s.branch     = 1'($urandom);
        s.pc         = $urandom;
        s.rs1_data   = $urandom;
        s.rs2_data   = $urandom;
        s.imm        = $urandom;
        s.funct      = 10'($urandom);
        s.rs1_addr   = 5'($urandom);
        s.rs2_addr   = 5'($urandom);
        s.rd_addr    = 5'($urandom);
        s.valid      = 1'($urandom);
        return s;
    endfunction

    task automatic check_fields(input string name, input fields_t act, input fields_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_counters(input string name, input logic [31:0] req_b, input logic [31:0] req_s);
`ifdef ID_EX_PERF_CNT_EN
        check_word({name, "_bubble_cnt"}, bus.bubble_cnt_o, req_b);
        check_word({name, "_stall_cnt"}, bus.stall_cnt_o, req_s);
`else
        if (req_b == req_s) begin
        end
`endif
    endtask

    // One clock of stimulus; the reference applies the priority rules and queues the result for the monitor
    task automatic cycle(input logic st, input logic sl, input logic fl, input fields_t in);
        exp_t e;
        @(negedge clk);
        bus.start_i    = st;
        bus.stall_i    = sl;
        bus.flush_i    = fl;
        bus.valid_i    = in.valid;
        bus.ALUOp_i    = in.alu_op;
        bus.ALUSrc_i   = in.alu_src;
        bus.RegWrite_i = in.reg_write;
        bus.MemWrite_i = in.mem_write;
        bus.MemRead_i  = in.mem_read;
        bus.MemtoReg_i = in.mem_to_reg;
        bus.Branch_i   = in.branch;
        bus.PC_i       = in.pc;
        bus.RS1data_i  = in.rs1_data;
        bus.RS2data_i  = in.rs2_data;
        bus.Imm_i      = in.imm;
        bus.funct_i    = in.funct;
        bus.RS1addr_i  = in.rs1_addr;
        bus.RS2addr_i  = in.rs2_addr;
        bus.RDaddr_i   = in.rd_addr;
        if (st) begin
            if (fl) begin
                model_f = '0;
                model_bubbles = model_bubbles + 32'd1;
            end else if (sl) begin
                model_stalls = model_stalls + 32'd1;
            end else begin
                model_f = in;
            end
        end
        e.f       = model_f;
        e.bubbles = model_bubbles;
        e.stalls  = model_stalls;
        exp_q.push_back(e);
    endtask

    // Reset pulse between edges: outputs must clear before the next rising edge
    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_f       = '0;
        model_bubbles = 32'd0;
        model_stalls  = 32'd0;
        check_fields("async_reset", sample_outputs(), '0);
        check_counters("async_reset", 32'd0, 32'd0);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every rising edge after stimulus, pop the expected stage and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_fields("stage", sample_outputs(), e.f);
                check_counters("stage", e.bubbles, e.stalls);
            end
        end
    end

    initial begin
        fields_t s;
        logic st;
        logic sl;
        logic fl;
        checks        = 0;
        failures      = 0;
        model_f       = '0;
        model_bubbles = 32'd0;
        model_stalls  = 32'd0;
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.stall_i   = 1'b0;
        bus.flush_i   = 1'b0;
        s             = random_fields();
        bus.valid_i   = 1'b1;
        bus.ALUOp_i   = s.alu_op;
        bus.ALUSrc_i  = s.alu_src;
        bus.RegWrite_i = s.reg_write;
        bus.MemWrite_i = s.mem_write;
        bus.MemRead_i = s.mem_read;
        bus.MemtoReg_i = s.mem_to_reg;
        bus.Branch_i  = s.branch;
        bus.PC_i      = s.pc;
        bus.RS1data_i = s.rs1_data;
        bus.RS2data_i = s.rs2_data;
        bus.Imm_i     = s.imm;
        bus.funct_i   = s.funct;
        bus.RS1addr_i = s.rs1_addr;
        bus.RS2addr_i = s.rs2_addr;
        bus.RDaddr_i  = s.rd_addr;
        repeat (3) @(negedge clk);
        check_fields("reset_state", sample_outputs(), '0);
        check_counters("reset_state", 32'd0, 32'd0);
        rst = 1'b0;

        s = '0;
        s.reg_write = 1'b1;
        s.alu_op    = 2'b10;
        s.rs1_data  = 32'h0000_0005;
        s.rd_addr   = 5'd7;
        s.valid     = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, s);

        repeat (3) cycle(1'b1, 1'b1, 1'b0, random_fields());

        s = random_fields();
        s.mem_write = 1'b1;
        s.rd_addr   = 5'd9;
        s.valid     = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, s);

        cycle(1'b1, 1'b0, 1'b0, random_fields());
        cycle(1'b1, 1'b1, 1'b1, random_fields());

        s = random_fields();
        s.valid = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, s);
        cycle(1'b0, 1'b0, 1'b1, random_fields());
        cycle(1'b0, 1'b1, 1'b0, random_fields());

        s = random_fields();
        s.valid     = 1'b0;
        s.reg_write = 1'b1;
        s.mem_write = 1'b1;
        s.rd_addr   = 5'd31;
        cycle(1'b1, 1'b0, 1'b0, s);

        cycle(1'b1, 1'b0, 1'b0, random_fields());
        mid_reset();
        cycle(1'b1, 1'b0, 1'b0, random_fields());

        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 9) != 0);
            sl = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 6) == 0);
            cycle(st, sl, fl, random_fields());
            if ($urandom_range(0, 79) == 0) begin
                mid_reset();
            end
        end

        @(posedge clk);
        #3;
        check_word("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
